// File: rtl/rand_range_gen_pkg.sv
// Shared types and LFSR tap masks for the rand_range_gen slice.
// Tap masks describe a right-shifting Galois LFSR; bit 0 is the feedback bit.
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } rand_state_t;

    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'hA3000000;

    // Returns zero for an unsupported length, which callers treat as illegal.
    function automatic logic [31:0] get_taps(input int lfsr_w);
        logic [31:0] taps;
        case (lfsr_w)
            8:       taps = {24'd0, LFSR_TAPS_8};
            16:      taps = {16'd0, LFSR_TAPS_16};
            24:      taps = {8'd0, LFSR_TAPS_24};
            32:      taps = LFSR_TAPS_32;
            default: taps = 32'd0;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/rand_range_gen_if.sv
// Request/response bundle of rand_range_gen: handshake, seed load and result.
// master = consumer of random values, slave = the generator.
interface rand_range_gen_if #(
    parameter int WIDTH  = 4,
    parameter int LFSR_W = 16
);
    logic              REQ;
    logic              ACK;
    logic              SEED_LD;
    logic [LFSR_W-1:0] SEED_IN;
    logic [WIDTH-1:0]  D;
    logic              VALID;

    modport master (
        output REQ, ACK, SEED_LD, SEED_IN,
        input  D, VALID
    );

    modport slave (
        input  REQ, ACK, SEED_LD, SEED_IN,
        output D, VALID
    );
endinterface

// File: rtl/rand_range_gen_lfsr.sv
// lfsr_core: free-running right-shifting Galois LFSR with runtime seed load.
// A zero load value is replaced by SEED so the register can never lock up at zero.
module lfsr_core
    import rand_pkg::*;
#(
    parameter int          LFSR_W = 16,
    parameter logic [31:0] SEED   = 32'h0000ACE1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LD,
    input  logic [LFSR_W-1:0] LD_VAL,
    output logic [LFSR_W-1:0] Q
);

    localparam logic [31:0]       TAPS_FULL = get_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS      = TAPS_FULL[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] SEED_W    = SEED[LFSR_W-1:0];

    logic [LFSR_W-1:0] q_reg;
    logic [LFSR_W-1:0] q_next;

    always_comb begin
        q_next = q_reg >> 1;
        if (LD) begin
            q_next = (LD_VAL == '0) ? SEED_W : LD_VAL;
        end else if (q_reg[0]) begin
            q_next = (q_reg >> 1) ^ TAPS;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_reg <= SEED_W;
        end else begin
            q_reg <= q_next;
        end
    end

    assign Q = q_reg;

endmodule

// File: rtl/rand_range_gen.sv
// rand_range_gen: uniform-ish value in 0..MAX_VAL by LFSR rejection sampling with modulo fallback.
// Optional RAND_STATS_EN adds saturating draw/reject/fallback counters.
module rand_range_gen
    import rand_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int          MAX_VAL   = 9,
    parameter int          LFSR_W    = 16,
    parameter logic [31:0] SEED      = 32'h0000ACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    rand_range_gen_if.slave   bus
`ifdef RAND_STATS_EN
    ,
    output logic [15:0]       DRAW_CNT,
    output logic [15:0]       REJ_CNT,
    output logic [15:0]       FALLBACK_CNT
`endif
);

    localparam logic [31:0] SEED_MASK = (LFSR_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LFSR_W) - 32'd1);

    generate
        if (MAX_VAL >= (2 ** WIDTH)) begin : g_bad_max_val
            $fatal(1, "rand_range_gen: MAX_VAL does not fit in WIDTH bits");
        end
        if (WIDTH > LFSR_W) begin : g_bad_width
            $fatal(1, "rand_range_gen: WIDTH exceeds LFSR_W");
        end
        if (get_taps(LFSR_W) == 32'd0) begin : g_bad_lfsr_w
            $fatal(1, "rand_range_gen: LFSR_W must be 8, 16, 24 or 32");
        end
        if ((SEED & SEED_MASK) == 32'd0) begin : g_bad_seed
            $fatal(1, "rand_range_gen: SEED is zero at LFSR_W bits");
        end
        if (MAX_TRIES < 1) begin : g_bad_tries
            $fatal(1, "rand_range_gen: MAX_TRIES must be at least 1");
        end
    endgenerate

    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
    // A full-range MAX_VAL never rejects, so the divisor only has to be legal there.
    localparam logic [WIDTH-1:0] MOD_DIV  = (MAX_VAL + 1 >= (2 ** WIDTH)) ? WIDTH'(1) : WIDTH'(MAX_VAL + 1);

    logic [LFSR_W-1:0] lfsr_q;
    logic [WIDTH-1:0]  cand;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .LD     (bus.SEED_LD),
        .LD_VAL (bus.SEED_IN),
        .Q      (lfsr_q)
    );

    assign cand = lfsr_q[WIDTH-1:0];

    generate
        if (WIDTH < LFSR_W) begin : g_hi_bits
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:WIDTH];
        end
    endgenerate

    rand_state_t      state_reg, state_next;
    logic [TRY_W-1:0] tries_reg, tries_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic             valid_reg, valid_next;

    always_comb begin
        state_next = state_reg;
        tries_next = tries_reg;
        d_next     = d_reg;
        valid_next = valid_reg;
        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                if (bus.REQ) begin
                    state_next = DRAW;
                    tries_next = '0;
                end
            end
            DRAW: begin
                if (cand <= MAX_V) begin
                    d_next     = cand;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end else if (tries_reg == LAST_TRY) begin
                    d_next     = cand % MOD_DIV;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end else begin
                    tries_next = tries_reg + TRY_ONE;
                end
            end
            HOLD: begin
                if (bus.ACK) begin
                    valid_next = 1'b0;
                    if (bus.REQ) begin
                        state_next = DRAW;
                        tries_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            tries_reg <= '0;
            d_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            tries_reg <= tries_next;
            d_reg     <= d_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.D     = d_reg;
    assign bus.VALID = valid_reg;

`ifdef RAND_STATS_EN
    logic        rej_ev;
    logic        fb_ev;
    logic        draw_ev;
    logic [15:0] draw_cnt_reg, rej_cnt_reg, fb_cnt_reg;

    // The fallback candidate is itself a rejection, so it bumps both counters.
    assign rej_ev  = (state_reg == DRAW) && (cand > MAX_V);
    assign fb_ev   = rej_ev && (tries_reg == LAST_TRY);
    assign draw_ev = valid_next && !valid_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            draw_cnt_reg <= '0;
            rej_cnt_reg  <= '0;
            fb_cnt_reg   <= '0;
        end else begin
            if (draw_ev && (draw_cnt_reg != 16'hFFFF)) draw_cnt_reg <= draw_cnt_reg + 16'd1;
            if (rej_ev && (rej_cnt_reg != 16'hFFFF))   rej_cnt_reg  <= rej_cnt_reg + 16'd1;
            if (fb_ev && (fb_cnt_reg != 16'hFFFF))     fb_cnt_reg   <= fb_cnt_reg + 16'd1;
        end
    end

    assign DRAW_CNT     = draw_cnt_reg;
    assign REJ_CNT      = rej_cnt_reg;
    assign FALLBACK_CNT = fb_cnt_reg;
`endif

endmodule
